// File: rtl/wb_bram_burst.sv
// Wishbone slave over a single-port block RAM: registered ack, 1-cycle access latency, one beat per clock in burst, never stalls.
// Incrementing/wrapping bursts (wb_cti/wb_bte) exist only when WB_BRAM_BURST_EN is defined; otherwise every access is classic.
module wb_bram_burst #(
   parameter  int MEM_ADR_WIDTH = 11,
   parameter  int DATA_WIDTH    = 32,
   localparam int SEL_WIDTH     = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_cyc,
   input  logic                  wb_stb,
   input  logic                  wb_we,
   input  logic [31:0]           wb_adr,
   input  logic [SEL_WIDTH-1:0]  wb_sel,
   input  logic [DATA_WIDTH-1:0] wb_dat_ms,
   output logic [DATA_WIDTH-1:0] wb_dat_sm,
   output logic                  wb_ack,
   input  logic [2:0]            wb_cti,
   input  logic [1:0]            wb_bte
);

   localparam int L     = $clog2(SEL_WIDTH);
   localparam int DEPTH = 1 << MEM_ADR_WIDTH;

   typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;

   state_t                   state_q, state_d;
   logic [MEM_ADR_WIDTH-1:0] adr_q, adr_d;
   logic                     ack_q, ack_d;
   logic [DATA_WIDTH-1:0]    dat_q;

   logic                     req;
   logic                     mem_we;
   logic                     rd_en;
   logic [MEM_ADR_WIDTH-1:0] adr_idx;
   logic [MEM_ADR_WIDTH-1:0] adr_nxt;
   logic [DATA_WIDTH-1:0]    mem [0:DEPTH-1];

   assign req     = wb_cyc & wb_stb;
   assign adr_idx = wb_adr[MEM_ADR_WIDTH+L-1:L];

   logic unused_adr;
   assign unused_adr = ^{wb_adr[31:MEM_ADR_WIDTH+L], wb_adr[L-1:0]};

`ifdef WB_BRAM_BURST_EN
   logic [MEM_ADR_WIDTH-1:0] wrap_mask;

   // Bits under the mask advance; bits above it stay put (all ones = linear).
   always_comb begin
      wrap_mask = '1;
      case (wb_bte)
         2'b01:   wrap_mask = MEM_ADR_WIDTH'(3);
         2'b10:   wrap_mask = MEM_ADR_WIDTH'(7);
         2'b11:   wrap_mask = MEM_ADR_WIDTH'(15);
         default: wrap_mask = '1;
      endcase
      adr_nxt = (adr_q & ~wrap_mask) | ((adr_q + MEM_ADR_WIDTH'(1)) & wrap_mask);
   end
`else
   logic unused_burst;
   assign unused_burst = ^{wb_cti, wb_bte};
   assign adr_nxt      = adr_q;
`endif

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      ack_d   = 1'b0;
      mem_we  = 1'b0;
      rd_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               adr_d = adr_idx;
               ack_d = 1'b1;
               rd_en = ~wb_we;
`ifdef WB_BRAM_BURST_EN
               state_d = (wb_cti == 3'b010) ? BURST : SINGLE;
`else
               state_d = SINGLE;
`endif
            end
         end
         SINGLE: begin
            // Either the beat completes or the master aborted; both return to IDLE.
            state_d = IDLE;
            mem_we  = req & ack_q & wb_we;
         end
`ifdef WB_BRAM_BURST_EN
         BURST: begin
            if (req & ack_q) begin
               mem_we = wb_we;
               if (wb_cti == 3'b010) begin
                  adr_d = adr_nxt;
                  ack_d = 1'b1;
                  rd_en = ~wb_we;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         adr_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         ack_q   <= ack_d;
      end
   end

   // Contents are never reset; a reset edge only suppresses the write.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int i = 0; i < SEL_WIDTH; i++) begin
            if (wb_sel[i]) mem[adr_q][i*8 +: 8] <= wb_dat_ms[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dat_q <= '0;
      end else if (rd_en) begin
         dat_q <= mem[adr_d];
      end
   end

   assign wb_dat_sm = dat_q;
   assign wb_ack    = ack_q;

endmodule

// File: tb/tb_wb_bram_burst.sv
// Scoreboarded bench for wb_bram_burst: driver pushes expected beats, negedge monitor pops on each completed ack.
module tb_wb_bram_burst;

   localparam int DEPTH = 2048;
`ifdef WB_BRAM_BURST_EN
   localparam bit BURST_BUILD = 1'b1;
`else
   localparam bit BURST_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_cyc, wb_stb, wb_we, wb_ack;
   logic [31:0] wb_adr, wb_dat_ms, wb_dat_sm;
   logic [3:0]  wb_sel;
   logic [2:0]  wb_cti;
   logic [1:0]  wb_bte;

   always #5 clk = ~clk;

   wb_bram_burst dut (
      .clk       (clk),
      .rst       (rst),
      .wb_cyc    (wb_cyc),
      .wb_stb    (wb_stb),
      .wb_we     (wb_we),
      .wb_adr    (wb_adr),
      .wb_sel    (wb_sel),
      .wb_dat_ms (wb_dat_ms),
      .wb_dat_sm (wb_dat_sm),
      .wb_ack    (wb_ack),
      .wb_cti    (wb_cti),
      .wb_bte    (wb_bte)
   );

   typedef struct packed {
      logic        rd;
      logic [31:0] dat;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] model [DEPTH];
   logic [31:0] last_rd;
   int          n_vec = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference address sequence: linear wraps the whole memory, wrap-N stays in its N-word block.
   function automatic int next_idx(input int a, input logic [1:0] bte);
      int n;
      if (bte == 2'b00) return (a + 1) % DEPTH;
      n = 2 << bte;
      return (a / n) * n + ((a % n) + 1) % n;
   endfunction

   always @(negedge clk) begin
      if (wb_cyc && wb_stb && wb_ack) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_ack: ack=1 with no beat outstanding, expected ack=0");
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.rd) begin
               check("rd_data", wb_dat_sm, mon_e.dat);
               last_rd = wb_dat_sm;
            end
         end
      end
   end

   task automatic beat(input logic we, input int idx, input logic [3:0] sel, input logic [31:0] dat,
                       input logic [2:0] cti, input logic [1:0] bte, input bit cont,
                       input bit junk, input bit do_rst);
      int          waited;
      logic [31:0] a;
      exp_t        e;
      a = 32'(idx) << 2;
      if (junk) a = a | ($urandom() & 32'hFFFF_E003);
      wb_cyc    = 1'b1;
      wb_stb    = 1'b1;
      wb_we     = we;
      wb_adr    = a;
      wb_sel    = sel;
      wb_dat_ms = dat;
      wb_cti    = cti;
      wb_bte    = bte;
      e.rd  = ~we;
      e.dat = model[idx];
      sb.push_back(e);
      waited = 0;
      @(negedge clk);
      while (!wb_ack && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      check("ack_latency", 32'(waited), (BURST_BUILD && cont) ? 32'd0 : 32'd1);
      if (do_rst) rst = 1'b1;
      @(posedge clk);
      #1;
      if (we && !do_rst) begin
         for (int i = 0; i < 4; i++) if (sel[i]) model[idx][i*8 +: 8] = dat[i*8 +: 8];
      end
   endtask

   task automatic end_cycle();
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_cti = 3'b000;
      @(negedge clk);
      check("ack_low_after", {31'd0, wb_ack}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   // base != 0 gives data base+beat, otherwise random data.
   task automatic txn(input logic we, input int start, input int len, input logic [1:0] bte,
                      input bit junk, input bit full_sel, input logic [31:0] base);
      int idx;
      idx = start;
      for (int b = 0; b < len; b++) begin
         logic [2:0]  cti;
         logic [3:0]  sel;
         logic [31:0] d;
         cti = (b == len - 1) ? ((len == 1 || $urandom_range(0, 1) == 0) ? 3'b000 : 3'b111) : 3'b010;
         sel = full_sel ? 4'hF : 4'($urandom());
         d   = (base != 0) ? base + 32'(b) : $urandom();
         beat(we, idx, sel, d, cti, bte, b > 0, junk, 1'b0);
         idx = next_idx(idx, bte);
      end
      end_cycle();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0;
      wb_sel = '0; wb_dat_ms = '0; wb_cti = '0; wb_bte = '0; last_rd = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ack", {31'd0, wb_ack}, 32'd0);
      check("reset_dat", wb_dat_sm, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int s = 0; s < DEPTH; s += 16) txn(1'b1, s, 16, 2'b00, 1'b0, 1'b1, 32'd0);

      txn(1'b1, 4, 1, 2'b00, 1'b0, 1'b1, 32'hDEADBEEF);
      txn(1'b0, 4, 1, 2'b00, 1'b0, 1'b1, 32'd0);
      check("classic_rw", last_rd, 32'hDEADBEEF);

      txn(1'b1, 8, 1, 2'b00, 1'b0, 1'b1, 32'h11223344);
      beat(1'b1, 8, 4'b0101, 32'hAABBCCDD, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
      end_cycle();
      txn(1'b0, 8, 1, 2'b00, 1'b0, 1'b1, 32'd0);
      check("byte_enable", last_rd, 32'h11BB33DD);

      txn(1'b1, 0, 4, 2'b00, 1'b0, 1'b1, 32'hA0);
      txn(1'b0, 0, 4, 2'b00, 1'b0, 1'b1, 32'd0);
      check("linear_burst_last", last_rd, 32'hA3);
      txn(1'b0, 2, 4, 2'b01, 1'b0, 1'b1, 32'd0);
      check("wrap4_last", last_rd, 32'hA1);
      txn(1'b1, 2047, 2, 2'b00, 1'b0, 1'b1, 32'hC0DE0000);
      txn(1'b0, 2047, 2, 2'b00, 1'b0, 1'b1, 32'd0);
      check("top_rollover", last_rd, 32'hC0DE0001);

      beat(1'b1, 100, 4'hF, 32'h55000000, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0);
      beat(1'b1, 101, 4'hF, 32'h55000001, 3'b010, 2'b00, 1'b1, 1'b0, 1'b0);
      wb_stb = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_ack", {31'd0, wb_ack}, 32'd0);
      wb_cyc = 1'b0;
      @(posedge clk);
      #1;
      beat(1'b1, 200, 4'hF, 32'h66000000, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0);
      beat(1'b1, 201, 4'hF, 32'h66000001, 3'b010, 2'b00, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      check("midrst_ack", {31'd0, wb_ack}, 32'd0);
      check("midrst_dat", wb_dat_sm, 32'd0);
      rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_cti = 3'b000;
      @(posedge clk);
      #1;
      txn(1'b0, 100, 4, 2'b00, 1'b0, 1'b1, 32'd0);
      txn(1'b0, 101, 1, 2'b00, 1'b0, 1'b1, 32'd0);
      check("abort_kept_beat2", last_rd, 32'h55000001);
      txn(1'b0, 102, 1, 2'b00, 1'b0, 1'b1, 32'd0);
      check("abort_no_beat3", {31'd0, last_rd == 32'h55000002}, 32'd0);
      txn(1'b0, 200, 2, 2'b00, 1'b0, 1'b1, 32'd0);
      txn(1'b0, 201, 1, 2'b00, 1'b0, 1'b1, 32'd0);
      check("rst_no_write", {31'd0, last_rd == 32'h66000001}, 32'd0);

      repeat (150) begin
         txn(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 8)),
             2'($urandom_range(0, 3)), 1'b1, 1'b0, 32'd0);
      end

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
